lfsr_ber_monitor: RTL and testbench
===================================

// Module: lfsr_ber_monitor
// PURPOSE
//  Downstream of the LFSR generator/checker top. Consumes the checker's per-bit
//  valid/error/lock outputs and accumulates link statistics: bits checked, bit errors,
//  loss-of-lock events and windowed error rate. A link FSM flags degraded links and
//  raises a sticky alarm. Counters are read through an atomic snapshot.
// PARAMETERS
//  CNT_W     32  width of bit/error counters (saturating)
//  LOL_W     16  width of loss-of-lock counter (saturating)
//  WIN_LOG2  10  window length = 2**WIN_LOG2 counted bits
//  ERR_THR    8  window errors >= ERR_THR -> degraded (1..2**WIN_LOG2)
// PORTS
//  clk           in   1      system clock, all logic on posedge
//  i_rst_n       in   1      asynchronous, active-low reset
//  i_soft_reset  in   1      sync clear: counters, window, FSM, alarm, snapshot regs
//  i_valid       in   1      checker produced a compared bit this cycle
//  i_err         in   1      compared bit mismatched (qualified by i_valid)
//  i_lock        in   1      checker lock status (level)
//  i_snap        in   1      snapshot request (level sampled each cycle)
//  o_bit_cnt     out  CNT_W  snapshotted bits-checked count
//  o_err_cnt     out  CNT_W  snapshotted bit-error count
//  o_lol_cnt     out  LOL_W  snapshotted loss-of-lock count
//  o_snap_valid  out  1      1-cycle pulse: snapshot registers updated
//  o_state       out  2      FSM state: 0 IDLE, 1 TRACK, 2 DEGRADED
//  o_degraded    out  1      registered, high iff state==DEGRADED
//  o_alarm       out  1      sticky; set on any lock loss; clear only by reset/soft reset
// BEHAVIOUR
//  - Reset (i_rst_n=0) and i_soft_reset: all outputs/counters 0, state IDLE. Soft reset
//    has priority over every other event in the same cycle.
//  - A bit is counted iff i_valid && i_lock && state!=IDLE. bit_cnt+1, err_cnt+i_err,
//    win_bits+1, win_errs+i_err. All counters saturate at all-ones, never wrap.
//  - IDLE -> TRACK: cycle with i_lock=1 (bit that cycle not counted); window cleared.
//  - Window end: the counted bit that makes win_bits == 2**WIN_LOG2. Compare
//    win_errs (including that bit) to ERR_THR. TRACK -> DEGRADED if >=, DEGRADED -> TRACK
//    if <, otherwise stay. Window counters restart at 0 next cycle.
//  - Lock loss: i_lock=0 while TRACK/DEGRADED -> IDLE next cycle, lol_cnt+1,
//    o_alarm=1. Bit in that cycle not counted. Lock loss wins over a window end.
//  - i_lock=0 in IDLE: no event.
//  - Snapshot: i_snap=1 in cycle N -> o_*_cnt take live counters including cycle-N
//    updates, visible and o_snap_valid=1 in cycle N+1. Back-to-back requests give
//    back-to-back pulses. Outputs hold between snapshots.
//  - o_state/o_degraded change in the cycle after the causing event.
// STRUCTURE
//  - lfsr_pkg.vh: localparams ST_IDLE/ST_TRACK/ST_DEGRADED, state width, default widths.
//    Shared with the top and the checker.
//  - Sub-module sat_counter #(W): clr, inc enable, inc amount (1 bit), saturating q.
//    Instantiated for bit, err, lol, win_errs.
//  - win_bits is a plain WIN_LOG2+1 counter in the FSM block.
// TESTING (bench with WIN_LOG2=4, ERR_THR=2, CNT_W=8, LOL_W=4)
//  1 Reset then lock=1, 16 valid clean bits, snap -> bit=16 err=0 lol=0, state TRACK,
//    o_snap_valid 1 cycle.
//  2 Window with errors on bits 3 and 9 -> DEGRADED after bit 16. Next window 1 error
//    -> TRACK.
//  3 Drop i_lock for 1 cycle in TRACK with i_valid=1 -> IDLE, lol=1, alarm=1, that bit
//    uncounted. Relock -> TRACK, alarm stays 1.
//  4 300 valid error bits -> bit_cnt=err_cnt=255 (saturated). 20 lock losses -> lol=15.
//  5 i_soft_reset with i_snap and i_lock drop same cycle -> all 0, no o_snap_valid, IDLE.
//  6 Assert i_rst_n=0 mid-window, async -> outputs 0 before next clk edge.

Source files
------------

// File: rtl/lfsr_ber_monitor_pkg.sv
// Shared types and default sizing for the BER monitor slice.
// State encoding matches the link-state field reported to software.
package lfsr_ber_monitor_pkg;

    localparam int unsigned STATE_W      = 2;
    localparam int unsigned DEF_CNT_W    = 32;
    localparam int unsigned DEF_LOL_W    = 16;
    localparam int unsigned DEF_WIN_LOG2 = 10;
    localparam int unsigned DEF_ERR_THR  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 2'd0,
        ST_TRACK    = 2'd1,
        ST_DEGRADED = 2'd2
    } state_e;

    function automatic logic state_is_active(input state_e s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/lfsr_ber_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; exposes next value for snapshots.
module lfsr_ber_monitor_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         inc_en_i,
    input  logic         inc_i,
    output logic [W-1:0] d_o,
    output logic [W-1:0] q_o
);

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next-count: clear wins, then increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_en_i && inc_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign d_o = cnt_d;
    assign q_o = cnt_q;

endmodule

// File: rtl/lfsr_ber_monitor.sv
// Link statistics for the LFSR checker: bit/error/loss-of-lock counts,
// windowed error-rate link FSM, sticky alarm and atomic counter snapshot.
module lfsr_ber_monitor
    import lfsr_ber_monitor_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned LOL_W    = DEF_LOL_W,
    parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2,
    parameter int unsigned ERR_THR  = DEF_ERR_THR
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_soft_reset,
    input  logic               i_valid,
    input  logic               i_err,
    input  logic               i_lock,
    input  logic               i_snap,
    output logic [CNT_W-1:0]   o_bit_cnt,
    output logic [CNT_W-1:0]   o_err_cnt,
    output logic [LOL_W-1:0]   o_lol_cnt,
    output logic               o_snap_valid,
    output logic [STATE_W-1:0] o_state,
    output logic               o_degraded,
    output logic               o_alarm
);

    localparam int unsigned   WB_W     = WIN_LOG2 + 1;
    localparam int unsigned   WE_W     = WB_W + 1;
    localparam logic [WB_W-1:0] WB_ONE   = WB_W'(1);
    localparam logic [WB_W-1:0] WIN_LAST = WB_W'((1 << WIN_LOG2) - 1);
    localparam logic [WE_W-1:0] THR      = WE_W'(ERR_THR);

    state_e             state_q;
    logic [WB_W-1:0]    win_bits_q;
    logic               degraded_q;
    logic               alarm_q;

    logic [CNT_W-1:0]   bit_cnt_d, bit_cnt_q;
    logic [CNT_W-1:0]   err_cnt_d, err_cnt_q;
    logic [LOL_W-1:0]   lol_cnt_d, lol_cnt_q;
    logic [WB_W-1:0]    win_errs_d, win_errs_q;

    logic [CNT_W-1:0]   bit_snap_q;
    logic [CNT_W-1:0]   err_snap_q;
    logic [LOL_W-1:0]   lol_snap_q;
    logic               snap_valid_q;

    logic               active_s;
    logic               counted_s;
    logic               lock_loss_s;
    logic               lock_acq_s;
    logic               win_end_s;
    logic               win_clr_s;
    logic [WE_W-1:0]    win_errs_sum_s;
    logic               win_bad_s;
    logic               unused_s;

    // Event decode for the current cycle.
    always_comb begin
        active_s       = state_is_active(state_q);
        counted_s      = i_valid & i_lock & active_s;
        lock_loss_s    = ~i_lock & active_s;
        lock_acq_s     = i_lock & ~active_s;
        win_end_s      = counted_s & (win_bits_q == WIN_LAST);
        win_clr_s      = i_soft_reset | lock_acq_s | lock_loss_s | win_end_s;
        // The closing bit's own error must take part in the threshold compare.
        win_errs_sum_s = {1'b0, win_errs_q} + {{WB_W{1'b0}}, (counted_s & i_err)};
        win_bad_s      = (win_errs_sum_s >= THR);
    end

    lfsr_ber_monitor_sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clk      (clk),
        .rst_n_i  (i_rst_n),
        .clr_i    (i_soft_reset),
        .inc_en_i (counted_s),
        .inc_i    (1'b1),
        .d_o      (bit_cnt_d),
        .q_o      (bit_cnt_q)
    );

    lfsr_ber_monitor_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk      (clk),
        .rst_n_i  (i_rst_n),
        .clr_i    (i_soft_reset),
        .inc_en_i (counted_s),
        .inc_i    (i_err),
        .d_o      (err_cnt_d),
        .q_o      (err_cnt_q)
    );

    lfsr_ber_monitor_sat_counter #(.W(LOL_W)) u_lol_cnt (
        .clk      (clk),
        .rst_n_i  (i_rst_n),
        .clr_i    (i_soft_reset),
        .inc_en_i (lock_loss_s),
        .inc_i    (1'b1),
        .d_o      (lol_cnt_d),
        .q_o      (lol_cnt_q)
    );

    lfsr_ber_monitor_sat_counter #(.W(WB_W)) u_win_errs (
        .clk      (clk),
        .rst_n_i  (i_rst_n),
        .clr_i    (win_clr_s),
        .inc_en_i (counted_s),
        .inc_i    (i_err),
        .d_o      (win_errs_d),
        .q_o      (win_errs_q)
    );

    assign unused_s = ^{bit_cnt_q, err_cnt_q, lol_cnt_q, win_errs_d};

    // Link FSM with window bit counter, degraded flag and sticky alarm.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            win_bits_q <= '0;
            degraded_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else if (i_soft_reset) begin
            state_q    <= ST_IDLE;
            win_bits_q <= '0;
            degraded_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_lock) begin
                        state_q    <= ST_TRACK;
                        win_bits_q <= '0;
                        degraded_q <= 1'b0;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_TRACK, ST_DEGRADED: begin
                    if (!i_lock) begin
                        state_q    <= ST_IDLE;
                        win_bits_q <= '0;
                        degraded_q <= 1'b0;
                        alarm_q    <= 1'b1;
                    end else if (win_end_s) begin
                        state_q    <= win_bad_s ? ST_DEGRADED : ST_TRACK;
                        degraded_q <= win_bad_s;
                        win_bits_q <= '0;
                    end else if (counted_s) begin
                        win_bits_q <= win_bits_q + WB_ONE;
                    end else begin
                        win_bits_q <= win_bits_q;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    win_bits_q <= '0;
                    degraded_q <= 1'b0;
                end
            endcase
        end
    end

    // Snapshot capture of next-state counters so cycle-N updates are included.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_snap_q   <= '0;
            err_snap_q   <= '0;
            lol_snap_q   <= '0;
            snap_valid_q <= 1'b0;
        end else if (i_soft_reset) begin
            bit_snap_q   <= '0;
            err_snap_q   <= '0;
            lol_snap_q   <= '0;
            snap_valid_q <= 1'b0;
        end else if (i_snap) begin
            bit_snap_q   <= bit_cnt_d;
            err_snap_q   <= err_cnt_d;
            lol_snap_q   <= lol_cnt_d;
            snap_valid_q <= 1'b1;
        end else begin
            snap_valid_q <= 1'b0;
        end
    end

    assign o_bit_cnt    = bit_snap_q;
    assign o_err_cnt    = err_snap_q;
    assign o_lol_cnt    = lol_snap_q;
    assign o_snap_valid = snap_valid_q;
    assign o_state      = state_q;
    assign o_degraded   = degraded_q;
    assign o_alarm      = alarm_q;

endmodule

// File: tb/tb_lfsr_ber_monitor.sv
// Directed bench for lfsr_ber_monitor with a behavioural link model and a
// snapshot scoreboard queue.
module tb_lfsr_ber_monitor;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_soft_reset;
    logic       i_valid;
    logic       i_err;
    logic       i_lock;
    logic       i_snap;
    logic [7:0] o_bit_cnt;
    logic [7:0] o_err_cnt;
    logic [3:0] o_lol_cnt;
    logic       o_snap_valid;
    logic [1:0] o_state;
    logic       o_degraded;
    logic       o_alarm;

    always #5 clk = ~clk;

    lfsr_ber_monitor #(
        .CNT_W    (8),
        .LOL_W    (4),
        .WIN_LOG2 (4),
        .ERR_THR  (2)
    ) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_soft_reset (i_soft_reset),
        .i_valid      (i_valid),
        .i_err        (i_err),
        .i_lock       (i_lock),
        .i_snap       (i_snap),
        .o_bit_cnt    (o_bit_cnt),
        .o_err_cnt    (o_err_cnt),
        .o_lol_cnt    (o_lol_cnt),
        .o_snap_valid (o_snap_valid),
        .o_state      (o_state),
        .o_degraded   (o_degraded),
        .o_alarm      (o_alarm)
    );

    typedef struct packed {
        logic [7:0] bc;
        logic [7:0] ec;
        logic [3:0] lc;
    } snap_t;

    snap_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    // Behavioural link model: 0 IDLE, 1 TRACK, 2 DEGRADED
    int m_state, m_bit, m_err, m_lol, m_wb, m_we, m_alarm;
    int m_sb, m_se, m_sl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_state = 0; m_bit = 0; m_err = 0; m_lol = 0;
        m_wb = 0; m_we = 0; m_alarm = 0;
        m_sb = 0; m_se = 0; m_sl = 0;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        snap_t x;
        check("state", 32'(o_state), 32'(m_state));
        check("degraded", 32'(o_degraded), 32'(m_state == 2));
        check("alarm", 32'(o_alarm), 32'(m_alarm));
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("snap_valid_hi", 32'(o_snap_valid), 32'd1);
            m_sb = int'(x.bc);
            m_se = int'(x.ec);
            m_sl = int'(x.lc);
        end else begin
            check("snap_valid_lo", 32'(o_snap_valid), 32'd0);
        end
        check("bit_cnt", 32'(o_bit_cnt), 32'(m_sb));
        check("err_cnt", 32'(o_err_cnt), 32'(m_se));
        check("lol_cnt", 32'(o_lol_cnt), 32'(m_sl));
    endtask

    // One clock cycle: drive at negedge, update model, check #1 after posedge.
    task automatic step(input logic v, input logic e, input logic l, input logic s, input logic sr);
        snap_t x;
        i_valid = v; i_err = e; i_lock = l; i_snap = s; i_soft_reset = sr;
        if (sr) begin
            model_clear();
        end else begin
            if (m_state == 0 && l) begin
                m_state = 1; m_wb = 0; m_we = 0;
            end else if (m_state != 0 && !l) begin
                m_state = 0; m_alarm = 1; m_wb = 0; m_we = 0;
                if (m_lol < 15) m_lol++;
            end else if (m_state != 0 && v) begin
                if (m_bit < 255) m_bit++;
                if (e && m_err < 255) m_err++;
                m_wb++;
                if (e) m_we++;
                if (m_wb == 16) begin
                    m_state = (m_we >= 2) ? 2 : 1;
                    m_wb = 0; m_we = 0;
                end
            end
            if (s) begin
                x.bc = 8'(m_bit); x.ec = 8'(m_err); x.lc = 4'(m_lol);
                exp_q.push_back(x);
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    initial begin
        i_rst_n = 1'b0; i_soft_reset = 1'b0; i_valid = 1'b0;
        i_err = 1'b0; i_lock = 1'b0; i_snap = 1'b0;
        model_clear();
        #3;
        check("reset_state", 32'(o_state), 32'd0);
        check("reset_bit", 32'(o_bit_cnt), 32'd0);
        check("reset_alarm", 32'(o_alarm), 32'd0);
        check("reset_snap_valid", 32'(o_snap_valid), 32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 1: lock, 16 clean bits, snapshot
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t1_bit", 32'(o_bit_cnt), 32'd16);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t1_state_track", 32'(o_state), 32'd1);

        // 2: errors on bits 3 and 9 -> DEGRADED, then 1 error -> TRACK
        for (int i = 1; i <= 16; i++) step(1'b1, (i == 3 || i == 9), 1'b1, 1'b0, 1'b0);
        check("t2_degraded", 32'(o_state), 32'd2);
        for (int i = 1; i <= 16; i++) step(1'b1, (i == 5), 1'b1, 1'b0, 1'b0);
        check("t2_back_track", 32'(o_state), 32'd1);

        // 3: one-cycle lock drop with valid -> IDLE, alarm; relock keeps alarm
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_idle", 32'(o_state), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t3_bit", 32'(o_bit_cnt), 32'd49);
        check("t3_lol", 32'(o_lol_cnt), 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_alarm_sticky", 32'(o_alarm), 32'd1);

        // 4: saturation of bit/err and loss-of-lock counters
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t4_bit_sat", 32'(o_bit_cnt), 32'd255);
        check("t4_err_sat", 32'(o_err_cnt), 32'd255);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t4_lol_sat", 32'(o_lol_cnt), 32'd15);

        // 5: soft reset beats snapshot and lock drop in the same cycle
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("t5_bit", 32'(o_bit_cnt), 32'd0);
        check("t5_lol", 32'(o_lol_cnt), 32'd0);
        check("t5_no_snap", 32'(o_snap_valid), 32'd0);
        check("t5_idle", 32'(o_state), 32'd0);
        check("t5_alarm", 32'(o_alarm), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 6: async reset mid-window clears outputs before the next edge
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t6_pre_bit", 32'(o_bit_cnt), 32'd9);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("t6_async_state", 32'(o_state), 32'd0);
        check("t6_async_alarm", 32'(o_alarm), 32'd0);
        check("t6_async_bit", 32'(o_bit_cnt), 32'd0);
        check("t6_async_lol", 32'(o_lol_cnt), 32'd0);
        model_clear();
        @(negedge clk);
        i_rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
